// File: rtl/seq_barrel_shifter.sv
// Iterative 8-bit barrel shifter: latches an operand on an accepted start and
// shifts or rotates it one position per clock, then presents the result with a
// one-cycle done pulse. Cycle-accurate partner of the combinational shifter.
module seq_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      outp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      outp_q  <= outp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; busy/done are computed from the next state so they stay registered.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    outp_d  = outp_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = inp;
          cnt_d   = shamt;
          dir_d   = dir;
          rot_d   = rot;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          if (dir_q) begin
            work_d = {(rot_q ? work_q[0] : 1'b0), work_q[WIDTH-1:1]};
          end else begin
            work_d = {work_q[WIDTH-2:0], (rot_q ? work_q[WIDTH-1] : 1'b0)};
          end
          cnt_d = cnt_q - SHW'(1);
        end else begin
          outp_d  = work_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign outp = outp_q;

endmodule
